// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm controller slice.
package alarm_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ALM_IDLE    = 2'd0,
    ALM_RINGING = 2'd1,
    ALM_SNOOZE  = 2'd2
  } alarm_state_t;

  localparam int RING_TIMEOUT_S_DEF = 60;
  localparam int SNOOZE_S_DEF       = 300;

endpackage

// File: rtl/alarm_match.sv
// Compares current HH:MM:00 against the alarm HH:MM and emits a one-cycle trigger
// on the first matching cycle; holding the time at the match does not retrigger.
module alarm_match
  import alarm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  bcd_t cur_h_tens,
  input  bcd_t cur_h_units,
  input  bcd_t cur_m_tens,
  input  bcd_t cur_m_units,
  input  bcd_t cur_s_tens,
  input  bcd_t cur_s_units,
  input  bcd_t alm_h_tens,
  input  bcd_t alm_h_units,
  input  bcd_t alm_m_tens,
  input  bcd_t alm_m_units,
  input  logic alarm_en,
  output logic trigger
);

  logic match;
  logic match_d;
  logic match_q;

  always_comb begin
    match = alarm_en
         && (cur_h_tens  == alm_h_tens)  && (cur_h_units == alm_h_units)
         && (cur_m_tens  == alm_m_tens)  && (cur_m_units == alm_m_units)
         && (cur_s_tens  == 4'd0)        && (cur_s_units == 4'd0);
    match_d = match;
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign trigger = match & ~match_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm IDLE/RINGING/SNOOZE FSM with registered outputs, one cycle after the trigger.
// The SNOOZE state exists only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_TIMEOUT_S = RING_TIMEOUT_S_DEF,
  parameter int SNOOZE_S       = SNOOZE_S_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_tick,
  input  bcd_t cur_h_tens,
  input  bcd_t cur_h_units,
  input  bcd_t cur_m_tens,
  input  bcd_t cur_m_units,
  input  bcd_t cur_s_tens,
  input  bcd_t cur_s_units,
  input  bcd_t alm_h_tens,
  input  bcd_t alm_h_units,
  input  bcd_t alm_m_tens,
  input  bcd_t alm_m_units,
  input  logic alarm_en,
  input  logic stop_btn,
  input  logic snooze_btn,
  output logic ringing,
  output logic buzzer,
  output logic snoozing
);

  localparam int RW = $clog2(RING_TIMEOUT_S + 1);
  localparam logic [RW-1:0] RING_MAX = RW'(RING_TIMEOUT_S);

  logic trigger;

  alarm_match u_match (
    .clk         (clk),
    .rst         (rst),
    .cur_h_tens  (cur_h_tens),
    .cur_h_units (cur_h_units),
    .cur_m_tens  (cur_m_tens),
    .cur_m_units (cur_m_units),
    .cur_s_tens  (cur_s_tens),
    .cur_s_units (cur_s_units),
    .alm_h_tens  (alm_h_tens),
    .alm_h_units (alm_h_units),
    .alm_m_tens  (alm_m_tens),
    .alm_m_units (alm_m_units),
    .alarm_en    (alarm_en),
    .trigger     (trigger)
  );

  alarm_state_t  state_d, state_q;
  logic [RW-1:0] ring_cnt_d, ring_cnt_q, ring_inc;
  logic          beep_d, beep_q;
  logic          ringing_d, ringing_q;
  logic          buzzer_d, buzzer_q;

`ifdef ALARM_SNOOZE_EN
  localparam int SW = $clog2(SNOOZE_S + 1);
  localparam logic [SW-1:0] SNOOZE_MAX = SW'(SNOOZE_S);
  logic [SW-1:0] snooze_cnt_d, snooze_cnt_q, snooze_inc;
  logic          snoozing_d, snoozing_q;
`else
  localparam int unused_snooze_s = SNOOZE_S;
  logic unused_snooze_btn;
  assign unused_snooze_btn = snooze_btn;
`endif

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    beep_d     = beep_q;
    // Saturating increment: the counter parks at its limit instead of wrapping.
    ring_inc   = (ring_cnt_q == RING_MAX) ? ring_cnt_q : ring_cnt_q + 1'b1;
`ifdef ALARM_SNOOZE_EN
    snooze_cnt_d = snooze_cnt_q;
    snooze_inc   = (snooze_cnt_q == SNOOZE_MAX) ? snooze_cnt_q : snooze_cnt_q + 1'b1;
`endif
    if (!alarm_en) begin
      state_d = ALM_IDLE;
    end else begin
      case (state_q)
        ALM_IDLE: begin
          if (trigger) begin
            state_d    = ALM_RINGING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end
        end
        ALM_RINGING: begin
          if (stop_btn) begin
            state_d = ALM_IDLE;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_btn) begin
            state_d      = ALM_SNOOZE;
            snooze_cnt_d = '0;
`endif
          end else if (sec_tick) begin
            ring_cnt_d = ring_inc;
            beep_d     = ~beep_q;
            if (ring_inc == RING_MAX) state_d = ALM_IDLE;
          end
        end
`ifdef ALARM_SNOOZE_EN
        ALM_SNOOZE: begin
          if (stop_btn) begin
            state_d = ALM_IDLE;
          end else if ((sec_tick && (snooze_inc == SNOOZE_MAX)) || trigger) begin
            state_d    = ALM_RINGING;
            ring_cnt_d = '0;
            beep_d     = 1'b1;
          end else if (sec_tick) begin
            snooze_cnt_d = snooze_inc;
          end
        end
`endif
        default: state_d = ALM_IDLE;
      endcase
    end
    ringing_d = (state_d == ALM_RINGING);
    buzzer_d  = ringing_d & beep_d;
`ifdef ALARM_SNOOZE_EN
    snoozing_d = (state_d == ALM_SNOOZE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALM_IDLE;
      ring_cnt_q <= '0;
      beep_q     <= 1'b0;
      ringing_q  <= 1'b0;
      buzzer_q   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= '0;
      snoozing_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      beep_q     <= beep_d;
      ringing_q  <= ringing_d;
      buzzer_q   <= buzzer_d;
`ifdef ALARM_SNOOZE_EN
      snooze_cnt_q <= snooze_cnt_d;
      snoozing_q   <= snoozing_d;
`endif
    end
  end

  assign ringing = ringing_q;
  assign buzzer  = buzzer_q;
`ifdef ALARM_SNOOZE_EN
  assign snoozing = snoozing_q;
`else
  assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with RING_TIMEOUT_S=5, SNOOZE_S=10.
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst, sec_tick, alarm_en, stop_btn, snooze_btn;
  logic [3:0] cur_h_tens, cur_h_units, cur_m_tens, cur_m_units, cur_s_tens, cur_s_units;
  logic [3:0] alm_h_tens, alm_h_units, alm_m_tens, alm_m_units;
  logic       ringing, buzzer, snoozing;
  logic [2:0] obs;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(.RING_TIMEOUT_S(5), .SNOOZE_S(10)) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_h_tens(cur_h_tens), .cur_h_units(cur_h_units),
    .cur_m_tens(cur_m_tens), .cur_m_units(cur_m_units),
    .cur_s_tens(cur_s_tens), .cur_s_units(cur_s_units),
    .alm_h_tens(alm_h_tens), .alm_h_units(alm_h_units),
    .alm_m_tens(alm_m_tens), .alm_m_units(alm_m_units),
    .alarm_en(alarm_en), .stop_btn(stop_btn), .snooze_btn(snooze_btn),
    .ringing(ringing), .buzzer(buzzer), .snoozing(snoozing)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h_tens  = 4'(h / 10);
    cur_h_units = 4'(h % 10);
    cur_m_tens  = 4'(m / 10);
    cur_m_units = 4'(m % 10);
    cur_s_tens  = 4'(s / 10);
    cur_s_units = 4'(s % 10);
  endtask

  task automatic set_alarm(input int h, input int m);
    alm_h_tens  = 4'(h / 10);
    alm_h_units = 4'(h % 10);
    alm_m_tens  = 4'(m / 10);
    alm_m_units = 4'(m % 10);
  endtask

  // The tick cycle sees the old digits; the counter shows the new time one cycle later.
  task automatic advance(input int h, input int m, input int s);
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
    set_time(h, m, s);
    cyc();
  endtask

  task automatic tick_only();
    sec_tick = 1'b1;
    cyc();
    sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sec_tick = 1'b0; alarm_en = 1'b0; stop_btn = 1'b0; snooze_btn = 1'b0;
    set_time(0, 0, 0);
    set_alarm(0, 0);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic arm_0730();
    do_reset();
    set_alarm(7, 30);
    set_time(7, 29, 59);
    alarm_en = 1'b1;
    cyc();
    advance(7, 30, 0);
  endtask

  task automatic test_reset();
    do_reset();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL reset_outputs: rbs=%b expected %b", obs, 3'b000); end
  endtask

  task automatic test_ring_buzzer();
    do_reset();
    set_alarm(7, 30);
    set_time(7, 29, 59);
    alarm_en = 1'b1;
    cyc();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL pre_match: rbs=%b expected %b", obs, 3'b000); end
    advance(7, 30, 0);
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL ring_start: rbs=%b expected %b", obs, 3'b110); end
    advance(7, 30, 1);
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b100) begin errors++; $display("FAIL beep_off_0301: rbs=%b expected %b", obs, 3'b100); end
    advance(7, 30, 2);
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL beep_on_0302: rbs=%b expected %b", obs, 3'b110); end
  endtask

  task automatic test_timeout();
    arm_0730();
    for (int i = 1; i <= 4; i++) begin
      tick_only();
      checks++;
      if (ringing !== 1'b1) begin errors++; $display("FAIL timeout_hold tick%0d: ringing=%b expected 1", i, ringing); end
    end
    tick_only();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL timeout_off: rbs=%b expected %b", obs, 3'b000); end
  endtask

  task automatic test_snooze();
    arm_0730();
    advance(7, 30, 1);
    advance(7, 30, 2);
    advance(7, 30, 3);
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    obs = {ringing, buzzer, snoozing};
`ifdef ALARM_SNOOZE_EN
    checks++;
    if (obs !== 3'b001) begin errors++; $display("FAIL snooze_enter: rbs=%b expected %b", obs, 3'b001); end
    for (int i = 1; i <= 9; i++) begin
      tick_only();
      obs = {ringing, buzzer, snoozing};
      checks++;
      if (obs !== 3'b001) begin errors++; $display("FAIL snooze_hold tick%0d: rbs=%b expected %b", i, obs, 3'b001); end
    end
    tick_only();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL snooze_rering: rbs=%b expected %b", obs, 3'b110); end
`else
    checks++;
    if (obs !== 3'b100) begin errors++; $display("FAIL snooze_ignored: rbs=%b expected %b", obs, 3'b100); end
    tick_only();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL no_snooze_tick4: rbs=%b expected %b", obs, 3'b110); end
    tick_only();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL no_snooze_timeout: rbs=%b expected %b", obs, 3'b000); end
`endif
  endtask

  task automatic test_both_buttons();
    arm_0730();
    stop_btn = 1'b1;
    snooze_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    snooze_btn = 1'b0;
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL stop_and_snooze: rbs=%b expected %b", obs, 3'b000); end
  endtask

  task automatic test_en_drop();
    arm_0730();
`ifdef ALARM_SNOOZE_EN
    snooze_btn = 1'b1;
    cyc();
    snooze_btn = 1'b0;
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b001) begin errors++; $display("FAIL en_drop_setup: rbs=%b expected %b", obs, 3'b001); end
`endif
    alarm_en = 1'b0;
    cyc();
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL en_drop: rbs=%b expected %b", obs, 3'b000); end
  endtask

  task automatic test_stop_hold();
    arm_0730();
    stop_btn = 1'b1;
    cyc();
    stop_btn = 1'b0;
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL stop: rbs=%b expected %b", obs, 3'b000); end
    for (int i = 0; i < 4; i++) cyc();
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL held_no_rering: ringing=%b expected 0", ringing); end
  endtask

  task automatic test_disabled();
    do_reset();
    set_alarm(7, 30);
    set_time(7, 29, 59);
    cyc();
    advance(7, 30, 0);
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL disabled_match: ringing=%b expected 0", ringing); end
    cyc();
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL disabled_after: ringing=%b expected 0", ringing); end
  endtask

  task automatic test_wrap();
    do_reset();
    set_alarm(0, 0);
    set_time(23, 59, 59);
    alarm_en = 1'b1;
    cyc();
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL wrap_pre: ringing=%b expected 0", ringing); end
    advance(0, 0, 0);
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL wrap_ring: rbs=%b expected %b", obs, 3'b110); end
  endtask

  task automatic test_rst_mid_ring();
    arm_0730();
    advance(7, 30, 1);
    rst = 1'b1;
    set_time(7, 31, 0);
    cyc();
    rst = 1'b0;
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b000) begin errors++; $display("FAIL rst_mid_ring: rbs=%b expected %b", obs, 3'b000); end
    set_alarm(8, 0);
    set_time(7, 59, 59);
    cyc();
    checks++;
    if (ringing !== 1'b0) begin errors++; $display("FAIL rst_then_idle: ringing=%b expected 0", ringing); end
    advance(8, 0, 0);
    obs = {ringing, buzzer, snoozing};
    checks++;
    if (obs !== 3'b110) begin errors++; $display("FAIL rst_then_ring: rbs=%b expected %b", obs, 3'b110); end
  endtask

  initial begin
    test_reset();
    test_ring_buzzer();
    test_timeout();
    test_snooze();
    test_both_buttons();
    test_en_drop();
    test_stop_hold();
    test_disabled();
    test_wrap();
    test_rst_mid_ring();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller downstream of the HH:MM:SS BCD time counter. Consumes its six BCD digits and the same 1 Hz pulse that advances it.
- Compares the current time against a stored alarm HH:MM and runs an IDLE/RINGING/SNOOZE state machine. Drives the ringing, buzzer and snooze indicators.
- Alarm digits come from the alarm-setting counter instance.

Parameters:
- RING_TIMEOUT_S, 60, seconds RINGING lasts before auto-off; must be >= 1.
- SNOOZE_S, 300, seconds spent in SNOOZE before re-ringing; must be >= 1; used only with SNOOZE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- sec_tick  in  1  one-cycle pulse per second, clk domain
- cur_h_tens, cur_h_units, cur_m_tens, cur_m_units, cur_s_tens, cur_s_units  in  4 each  current time, BCD
- alm_h_tens, alm_h_units, alm_m_tens, alm_m_units  in  4 each  alarm time, BCD
- alarm_en  in  1  level; alarm armed when 1
- stop_btn  in  1  one-cycle debounced pulse
- snooze_btn  in  1  one-cycle debounced pulse
- ringing  out  1  high in RINGING
- buzzer  out  1  1 Hz on/off beep pattern while ringing
- snoozing  out  1  high in SNOOZE

Behaviour:
- All outputs are registered. Reset values: state=IDLE, ringing=0, buzzer=0, snoozing=0, all counters=0, match_q=0.
- Match condition (combinational): alarm_en, hours equal alarm hours, minutes equal alarm minutes, cur_s_tens=0 and cur_s_units=0.
- match_q registers the match every cycle. trigger = match & ~match_q, so there is exactly one trigger per matching minute. Holding the time at the match does not retrigger.
- Latency: ringing=1 and buzzer=1 in the cycle after the digits first equal the match.
- Transition priority, highest first: rst > !alarm_en > stop_btn > snooze_btn > counter expiry > trigger.
- IDLE:
  - trigger -> RINGING; ring_cnt=0, beep_phase=1.
- RINGING:
  - each sec_tick: ring_cnt+1 and beep_phase toggles.
  - when ring_cnt reaches RING_TIMEOUT_S on a tick -> IDLE.
  - stop_btn -> IDLE.
  - snooze_btn -> SNOOZE; snooze_cnt=0.
  - trigger while RINGING is ignored.
- SNOOZE:
  - each sec_tick: snooze_cnt+1.
  - when snooze_cnt reaches SNOOZE_S -> RINGING; ring_cnt=0, beep_phase=1.
  - stop_btn -> IDLE.
  - trigger -> RINGING; ring_cnt=0, beep_phase=1.
- alarm_en=0 in any state -> IDLE next cycle; outputs low.
- stop_btn and snooze_btn in the same cycle: stop wins -> IDLE.
- Buttons in IDLE are ignored.
- Outputs: ringing=(state==RINGING); buzzer=ringing & beep_phase; snoozing=(state==SNOOZE).
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- Inputs are not range-checked. Invalid BCD simply never matches unless the alarm digits are equally invalid.
- rst mid-RINGING or mid-SNOOZE: all outputs 0 the following cycle.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snooze_cnt and SNOOZE_S behave as above.
- Undefined: no SNOOZE state or counter; snooze_btn is ignored, snoozing is tied 0, and only stop, timeout or alarm_en=0 end RINGING.

Decomposition:
- Package alarm_pkg:
  - typedef bcd_t (logic [3:0]).
  - enum alarm_state_t {ALM_IDLE, ALM_RINGING, ALM_SNOOZE}.
  - default constants RING_TIMEOUT_S_DEF=60 and SNOOZE_S_DEF=300.
- One sub-module, alarm_match: the digit comparator plus match_q register, outputting the trigger pulse.
- The FSM and counters stay in alarm_ctrl.

Test Plan:
- Alarm 07:30, alarm_en=1, time advanced 07:29:59 -> 07:30:00: ringing=1, buzzer=1 one cycle later. At 07:30:01: ringing=1, buzzer=0. At 07:30:02: buzzer=1.
- RING_TIMEOUT_S=5, no buttons: ringing drops to 0 the cycle after the 5th sec_tick following the trigger.
- SNOOZE_S=10, ALARM_SNOOZE_EN defined, snooze_btn at 07:30:03: ringing=0, snoozing=1. After the 10th tick: ringing=1, buzzer=1, snoozing=0.
- stop_btn and snooze_btn in the same cycle while RINGING -> IDLE, all outputs 0. Separate run: alarm_en dropped mid-SNOOZE -> snoozing=0 next cycle.
- Digits held at 07:30:00 after stop_btn: no re-ring. Separate run: alarm_en=0 across 07:30:00: ringing never asserts. Separate run: alarm 00:00, time 23:59:59 -> 00:00:00 wrap: rings.
- rst pulsed during RINGING: ringing=buzzer=snoozing=0 next cycle. A later match rings normally.
